// File: rtl/axi_lite_mem_slave_if.sv
// Five-channel rdy/ack bus between an AXI-lite-style master and the memory slave.
// Each channel uses X_rdy as its valid and X_ack as its accept.
interface axi_lite_mem_slave_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic            aw_rdy;
  logic            aw_ack;
  logic [AW-1:0]   aw;
  logic            w_rdy;
  logic            w_ack;
  logic [DW-1:0]   w;
  logic [DW/8-1:0] w_strb;
  logic            b_rdy;
  logic            b_ack;
  logic [1:0]      b;
  logic            ar_rdy;
  logic            ar_ack;
  logic [AW-1:0]   ar;
  logic            r_rdy;
  logic            r_ack;
  logic [DW-1:0]   r;
  logic [1:0]      r_resp;

  modport slave (
    input  aw_rdy, aw, w_rdy, w, w_strb, b_ack, ar_rdy, ar, r_ack,
    output aw_ack, w_ack, b_rdy, b, ar_ack, r_rdy, r, r_resp
  );

  modport master (
    output aw_rdy, aw, w_rdy, w, w_strb, b_ack, ar_rdy, ar, r_ack,
    input  aw_ack, w_ack, b_rdy, b, ar_ack, r_rdy, r, r_resp
  );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// Register-array memory behind an AXI-lite-style slave: byte-strobed writes,
// SLVERR for out-of-range word addresses and a fixed read latency of RD_LAT.
module axi_lite_mem_slave #(
  parameter int AW     = 6,
  parameter int DW     = 32,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_lite_mem_slave_if.slave    bus
);
  localparam int NB    = DW / 8;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;

  logic [DW-1:0]    mem_reg [DEPTH];
  logic             aw_full_reg;
  logic [AW-1:0]    aw_addr_reg;
  logic             w_full_reg;
  logic [DW-1:0]    w_data_reg;
  logic [NB-1:0]    w_strb_reg;
  logic             b_rdy_reg;
  logic [1:0]       b_reg;
  logic             commit;
  logic             aw_in_range;
  logic [DEPTH-1:0] word_we;

  rd_state_t        rd_state_reg, rd_state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [AW-1:0]    ar_addr_reg, ar_addr_next;
  logic [DW-1:0]    r_reg, r_next;
  logic [1:0]       r_resp_reg, r_resp_next;
  logic [DW-1:0]    rd_word;
  logic             ar_in_range;
  logic             ar_ack_int;
  logic             r_rdy_int;

  // Acks are forced low while reset is asserted so every output reads 0.
  assign bus.aw_ack = rst && !aw_full_reg;
  assign bus.w_ack  = rst && !w_full_reg;
  assign bus.b_rdy  = b_rdy_reg;
  assign bus.b      = b_reg;
  assign bus.ar_ack = ar_ack_int;
  assign bus.r_rdy  = r_rdy_int;
  assign bus.r      = r_reg;
  assign bus.r_resp = r_resp_reg;

  assign commit      = aw_full_reg && w_full_reg && !b_rdy_reg;
  assign aw_in_range = {1'b0, aw_addr_reg} < DEPTH_EXT;
  assign ar_in_range = {1'b0, ar_addr_reg} < DEPTH_EXT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_full_reg <= 1'b0;
      aw_addr_reg <= '0;
      w_full_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      b_rdy_reg   <= 1'b0;
      b_reg       <= 2'd0;
    end else begin
      if (commit) begin
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
        b_rdy_reg   <= 1'b1;
        b_reg       <= aw_in_range ? 2'd0 : 2'd2;
      end else if (b_rdy_reg && bus.b_ack) begin
        b_rdy_reg <= 1'b0;
      end
      if (bus.aw_rdy && bus.aw_ack) begin
        aw_full_reg <= 1'b1;
        aw_addr_reg <= bus.aw;
      end
      if (bus.w_rdy && bus.w_ack) begin
        w_full_reg <= 1'b1;
        w_data_reg <= bus.w;
        w_strb_reg <= bus.w_strb;
      end
    end
  end

  // Out-of-range addresses match no word, so the memory is left untouched.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
    assign word_we[gi] = commit && (aw_addr_reg == AW'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < NB; j++) begin
          if (word_we[i] && w_strb_reg[j]) begin
            mem_reg[i][8*j +: 8] <= w_data_reg[8*j +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ar_addr_reg == AW'(i)) begin
        rd_word = mem_reg[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_reg <= RD_IDLE;
      cnt_reg      <= '0;
      ar_addr_reg  <= '0;
      r_reg        <= '0;
      r_resp_reg   <= 2'd0;
    end else begin
      rd_state_reg <= rd_state_next;
      cnt_reg      <= cnt_next;
      ar_addr_reg  <= ar_addr_next;
      r_reg        <= r_next;
      r_resp_reg   <= r_resp_next;
    end
  end

  // The sample edge reads mem_reg before any same-edge commit lands: old data wins.
  always_comb begin
    rd_state_next = rd_state_reg;
    cnt_next      = cnt_reg;
    ar_addr_next  = ar_addr_reg;
    r_next        = r_reg;
    r_resp_next   = r_resp_reg;
    ar_ack_int    = 1'b0;
    r_rdy_int     = 1'b0;
    case (rd_state_reg)
      RD_IDLE: begin
        ar_ack_int = rst;
        if (bus.ar_rdy && ar_ack_int) begin
          rd_state_next = RD_WAIT;
          cnt_next      = CNT_W'(RD_LAT - 1);
          ar_addr_next  = bus.ar;
        end
      end
      RD_WAIT: begin
        if (cnt_reg == '0) begin
          rd_state_next = RD_RESP;
          r_next        = ar_in_range ? rd_word : '0;
          r_resp_next   = ar_in_range ? 2'd0 : 2'd2;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      RD_RESP: begin
        r_rdy_int = 1'b1;
        if (bus.r_ack) begin
          rd_state_next = RD_IDLE;
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Randomised bench for axi_lite_mem_slave against a word-array reference model
// with byte-strobe and address-range rules.
module tb_axi_lite_mem_slave;
  localparam int AW     = 6;
  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [DW-1:0] model_mem [2**AW];

  axi_lite_mem_slave_if #(.AW(AW), .DW(DW)) bus ();

  axi_lite_mem_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2**AW; i++) model_mem[i] = '0;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    if (int'(a) < DEPTH)
      for (int j = 0; j < 4; j++)
        if (s[j]) model_mem[a][8*j +: 8] = d[8*j +: 8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_aw_ack"}, 64'(bus.aw_ack), 0);
    check({tag, "_w_ack"},  64'(bus.w_ack),  0);
    check({tag, "_ar_ack"}, 64'(bus.ar_ack), 0);
    check({tag, "_b_rdy"},  64'(bus.b_rdy),  0);
    check({tag, "_b"},      64'(bus.b),      0);
    check({tag, "_r_rdy"},  64'(bus.r_rdy),  0);
    check({tag, "_r"},      64'(bus.r),      0);
    check({tag, "_r_resp"}, 64'(bus.r_resp), 0);
  endtask

  // Offers the enabled aw/w channels and returns once both have transferred.
  task automatic push(input bit en_aw, input bit en_w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [3:0] s);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = !en_aw; w_done = !en_w; n = 0;
    if (en_aw) begin bus.aw = a; bus.aw_rdy = 1'b1; end
    if (en_w)  begin bus.w = d; bus.w_strb = s; bus.w_rdy = 1'b1; end
    while (!(aw_done && w_done) && n < 40) begin
      aw_hs = bus.aw_rdy && bus.aw_ack;
      w_hs  = bus.w_rdy && bus.w_ack;
      tick();
      n++;
      if (aw_hs) begin aw_done = 1'b1; bus.aw_rdy = 1'b0; end
      if (w_hs)  begin w_done = 1'b1;  bus.w_rdy = 1'b0;  end
    end
    if (!(aw_done && w_done)) check("push_timeout", 0, 1);
  endtask

  task automatic wait_b(input logic [1:0] exp_b);
    int lat;
    lat = 0;
    bus.b_ack = 1'b1;
    while (!bus.b_rdy && lat < 20) begin tick(); lat++; end
    check("b_latency", 64'(lat), 1);
    check("b_resp", 64'(bus.b), 64'(exp_b));
    tick();
    bus.b_ack = 1'b0;
    check("b_rdy_clear", 64'(bus.b_rdy), 0);
  endtask

  // mode 0: aw and w together; 1: w first; 2: aw first; gap idle cycles between.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] s, input int mode, input int gap);
    logic [1:0] exp_b;
    exp_b = (int'(a) < DEPTH) ? 2'd0 : 2'd2;
    if (mode == 0) push(1, 1, a, d, s);
    else begin
      push(mode == 2, mode == 1, a, d, s);
      for (int i = 0; i < gap; i++) begin
        tick();
        check("half_no_commit", 64'(bus.b_rdy), 0);
      end
      push(mode == 1, mode == 2, a, d, s);
    end
    wait_b(exp_b);
    model_write(a, d, s);
    $display("wr addr=%0d data=0x%08h strb=0x%0h mode=%0d b=%0d", a, d, s, mode, exp_b);
  endtask

  task automatic start_read(input logic [AW-1:0] a);
    int n;
    n = 0;
    bus.ar = a;
    bus.ar_rdy = 1'b1;
    while (!bus.ar_ack && n < 40) begin tick(); n++; end
    tick();
    bus.ar_rdy = 1'b0;
    if (n >= 40) check("ar_timeout", 0, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int lat;
    logic [DW-1:0] exp_r;
    logic [1:0] exp_resp;
    exp_r    = (int'(a) < DEPTH) ? model_mem[a] : '0;
    exp_resp = (int'(a) < DEPTH) ? 2'd0 : 2'd2;
    start_read(a);
    lat = 0;
    while (!bus.r_rdy && lat < 20) begin tick(); lat++; end
    check("r_latency", 64'(lat), 64'(RD_LAT));
    check("r_data", 64'(bus.r), 64'(exp_r));
    check("r_resp", 64'(bus.r_resp), 64'(exp_resp));
    bus.r_ack = 1'b1;
    tick();
    bus.r_ack = 1'b0;
    check("r_rdy_clear", 64'(bus.r_rdy), 0);
    check("ar_ack_back", 64'(bus.ar_ack), 1);
    $display("rd addr=%0d data=0x%08h resp=%0d", a, bus.r, bus.r_resp);
  endtask

  initial begin
    logic [AW-1:0] a;
    model_clear();
    bus.aw_rdy = 0; bus.aw = '0; bus.w_rdy = 0; bus.w = '0; bus.w_strb = '0;
    bus.b_ack = 0; bus.ar_rdy = 0; bus.ar = '0; bus.r_ack = 0;

    #3;
    check_all_zero("in_reset");
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rel_aw_ack", 64'(bus.aw_ack), 1);
    check("rel_w_ack",  64'(bus.w_ack),  1);
    check("rel_ar_ack", 64'(bus.ar_ack), 1);
    check("rel_b_rdy",  64'(bus.b_rdy),  0);
    check("rel_r_rdy",  64'(bus.r_rdy),  0);
    do_read(6'd5);

    do_write(6'd3, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(6'd3);

    // w three cycles ahead of aw, partial strobe over a known word
    do_write(6'd7, 32'hAABBCCDD, 4'hF, 0, 0);
    push(0, 1, 6'd7, 32'h11223344, 4'h5);
    for (int i = 0; i < 3; i++) begin
      check("wfirst_aw_ack", 64'(bus.aw_ack), 1);
      check("wfirst_w_ack",  64'(bus.w_ack),  0);
      check("wfirst_no_b",   64'(bus.b_rdy),  0);
      tick();
    end
    push(1, 0, 6'd7, 32'h11223344, 4'h5);
    wait_b(2'd0);
    model_write(6'd7, 32'h11223344, 4'h5);
    do_read(6'd7);
    check("strb_word7", 64'(model_mem[7]), 64'h0000_0000_AA22_CC44);

    do_write(6'd20, 32'h1, 4'hF, 0, 0);
    do_read(6'd20);
    do_read(6'd63);
    do_write(6'd9, 32'hCAFEF00D, 4'h0, 0, 0);
    do_read(6'd9);

    // b held off: second pair fills both buffers, commits after the first b handshake
    push(1, 1, 6'd1, 32'h01010101, 4'hF);
    tick();
    check("stall_b1_rdy", 64'(bus.b_rdy), 1);
    push(1, 1, 6'd2, 32'h02020202, 4'hF);
    for (int i = 0; i < 4; i++) begin
      check("stall_b_rdy", 64'(bus.b_rdy), 1);
      check("stall_b",     64'(bus.b), 0);
      check("stall_aw_ack", 64'(bus.aw_ack), 0);
      check("stall_w_ack",  64'(bus.w_ack), 0);
      tick();
    end
    bus.b_ack = 1'b1;
    tick();
    bus.b_ack = 1'b0;
    check("stall_b_hs_clear", 64'(bus.b_rdy), 0);
    model_write(6'd1, 32'h01010101, 4'hF);
    tick();
    check("stall_second_commit", 64'(bus.b_rdy), 1);
    bus.b_ack = 1'b1;
    tick();
    bus.b_ack = 1'b0;
    model_write(6'd2, 32'h02020202, 4'hF);
    do_read(6'd1);
    do_read(6'd2);

    for (int k = 0; k < 60; k++) begin
      a = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, DEPTH - 1)) : 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
      else
        do_read(a);
    end

    // reset with a read response pending and the w buffer full
    start_read(6'd3);
    for (int n = 0; n < 20 && !bus.r_rdy; n++) tick();
    check("pre_rst_r_rdy", 64'(bus.r_rdy), 1);
    push(0, 1, 6'd0, 32'h5A5A5A5A, 4'hF);
    check("pre_rst_w_ack", 64'(bus.w_ack), 0);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_clear();
    tick();
    rst = 1'b1;
    #1;
    check("post_rst_r_rdy", 64'(bus.r_rdy), 0);
    check("post_rst_w_ack", 64'(bus.w_ack), 1);
    check("post_rst_aw_ack", 64'(bus.aw_ack), 1);
    do_read(6'd3);
    do_read(6'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
